// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg -- shared types and constants for the fp_add binary32 adder.
//
// Contents:
//   EXP_W, FRAC_W, BIAS, EXP_MAX  binary32 field geometry
//   QNAN                          canonical quiet NaN returned for invalid ops
//   LATENCY                       cycles from the first edge after reset
//                                 release to done=1 (fixed, informational)
//   fp32_t                        packed {sign, exp, frac} view of a binary32
//   fp_state_e                    one state per pipeline step of the FSM
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int LATENCY = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_UNPACK,
    ST_ALIGN,
    ST_ADDSUB,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_state_e;

endpackage : fp_pkg

// File: rtl/fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc -- combinational 27-bit leading-zero counter.
//
// Ports:
//   data_i  [26:0]  value to scan, bit 26 is the most significant
//   cnt_o   [4:0]   number of zeros above the highest set bit (27 if zero)
// ---------------------------------------------------------------------------
module fp_lzc (
  input  logic [26:0] data_i,
  output logic [4:0]  cnt_o
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_o = 5'd27;
    // Scanning upward lets the highest set bit win the last assignment.
    for (int i = 0; i < 27; i++) begin
      if (data_i[i]) cnt_o = 5'(26 - i);
    end
  end

endmodule : fp_lzc

// File: rtl/fp_add.sv
// ---------------------------------------------------------------------------
// fp_add -- multi-cycle IEEE-754 binary32 adder, round-to-nearest-even.
//
// Every operation is armed by releasing the reset: operands are captured on
// the first rising edge afterwards and the FSM walks
//   UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE
// one state per clock, so done rises on the fifth edge. result/done then hold
// until reset is asserted again; input changes are ignored meanwhile.
// Denormal inputs are flushed to zero.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset; release starts an operation
//   dataa   operand A (binary32), stable from reset release to capture
//   datab   operand B (binary32)
//   result  A+B (binary32), valid when done=1, zero otherwise
//   done    high once result is valid
//
// Configuration:
//   FP_ADD_SPECIALS_EN  when defined, exponent-255 inputs are decoded as
//                       inf/NaN. When undefined they are treated as ordinary
//                       finite values (deterministic, unspecified result);
//                       overflow to infinity applies in both builds.
// ---------------------------------------------------------------------------
module fp_add
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);

  fp_state_e state_q, state_d;

  // UNPACK stage: X is the operand with the larger magnitude.
  logic        sx_q, sx_d, sy_q, sy_d;
  logic [7:0]  ex_q, ex_d, ey_q, ey_d;
  logic [23:0] mx_q, mx_d, my_q, my_d;

  // ALIGN stage: Y significand with guard/round/sticky appended.
  logic [26:0] my_al_q, my_al_d;

  // ADDSUB stage: 28-bit sum, bit 27 is the carry.
  logic [27:0] sum_q, sum_d;
  logic        sign_q, sign_d;

  // NORM stage: normalised significand (bit 26 hidden, [2:0] = G/R/S).
  logic [26:0]       n_q, n_d;
  logic signed [9:0] exp_n_q, exp_n_d;
  logic              zero_q, zero_d;

  logic [31:0] result_q, result_d;
  logic        done_q;

  logic [4:0]  lzc;

`ifdef FP_ADD_SPECIALS_EN
  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_ADDSUB;
      ST_ADDSUB: state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_UNPACK;
    endcase
  end

  // -------------------------------------------------------------------------
  // UNPACK: decode, flush denormals, order by magnitude.
  // -------------------------------------------------------------------------
  fp32_t       op_a, op_b;
  logic [23:0] ma, mb;
  logic        a_ge_b;

  always_comb begin
    op_a = fp32_t'(dataa);
    op_b = fp32_t'(datab);
    ma   = (op_a.exp == '0) ? 24'd0 : {1'b1, op_a.frac};
    mb   = (op_b.exp == '0) ? 24'd0 : {1'b1, op_b.frac};
    // The flushed significand is used so a denormal compares as zero.
    a_ge_b = {op_a.exp, ma[22:0]} >= {op_b.exp, mb[22:0]};
    if (a_ge_b) begin
      sx_d = op_a.sign; ex_d = op_a.exp; mx_d = ma;
      sy_d = op_b.sign; ey_d = op_b.exp; my_d = mb;
    end else begin
      sx_d = op_b.sign; ex_d = op_b.exp; mx_d = mb;
      sy_d = op_a.sign; ey_d = op_a.exp; my_d = ma;
    end
  end

`ifdef FP_ADD_SPECIALS_EN
  logic a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_nan = (op_a.exp == 8'(EXP_MAX)) && (op_a.frac != '0);
    b_nan = (op_b.exp == 8'(EXP_MAX)) && (op_b.frac != '0);
    a_inf = (op_a.exp == 8'(EXP_MAX)) && (op_a.frac == '0);
    b_inf = (op_b.exp == 8'(EXP_MAX)) && (op_b.frac == '0);
    spec_d = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign))) begin
      spec_val_d = QNAN;
    end else if (a_inf) begin
      spec_val_d = {op_a.sign, 8'(EXP_MAX), 23'd0};
    end else begin
      spec_val_d = {op_b.sign, 8'(EXP_MAX), 23'd0};
    end
  end
`endif

  // -------------------------------------------------------------------------
  // ALIGN: right-shift Y by the exponent gap, collecting lost bits as sticky.
  // -------------------------------------------------------------------------
  logic [7:0]  exp_diff;
  logic [53:0] wide;

  always_comb begin
    exp_diff = ex_q - ey_q;
    // Upper half is the shifted value, lower half catches what fell off.
    wide     = {my_q, 3'b000, 27'd0} >> exp_diff;
    if (exp_diff >= 8'd26) begin
      my_al_d = {26'd0, |my_q};
    end else begin
      my_al_d = {wide[53:28], wide[27] | (|wide[26:0])};
    end
  end

  // -------------------------------------------------------------------------
  // ADDSUB: |X| >= |Y|, so the difference never goes negative.
  // -------------------------------------------------------------------------
  always_comb begin
    sign_d = sx_q;
    if (sx_q == sy_q) sum_d = {1'b0, mx_q, 3'b000} + {1'b0, my_al_q};
    else              sum_d = {1'b0, mx_q, 3'b000} - {1'b0, my_al_q};
  end

  // -------------------------------------------------------------------------
  // NORM
  // -------------------------------------------------------------------------
  fp_lzc u_lzc (
    .data_i (sum_q[26:0]),
    .cnt_o  (lzc)
  );

  always_comb begin
    zero_d = (sum_q == '0);
    if (sum_q[27]) begin
      n_d     = {sum_q[27:2], sum_q[1] | sum_q[0]};
      exp_n_d = $signed({2'b00, ex_q}) + 10'sd1;
    end else begin
      n_d     = sum_q[26:0] << lzc;
      exp_n_d = $signed({2'b00, ex_q}) - $signed({5'd0, lzc});
    end
  end

  // -------------------------------------------------------------------------
  // ROUND: nearest-even on G/R/S, renormalise on mantissa overflow, pack.
  // -------------------------------------------------------------------------
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;

  always_comb begin
    round_up = n_q[2] & (n_q[1] | n_q[0] | n_q[3]);
    mant_r   = {1'b0, n_q[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      exp_r  = exp_n_q + 10'sd1;
      frac_r = mant_r[23:1];
    end else begin
      exp_r  = exp_n_q;
      frac_r = mant_r[22:0];
    end

    if (zero_q)                result_d = 32'd0;
    else if (exp_r <= 10'sd0)  result_d = {sign_q, 31'd0};
    else if (exp_r >= EXP_OVF) result_d = {sign_q, 8'(EXP_MAX), 23'd0};
    else                       result_d = {sign_q, exp_r[7:0], frac_r};
`ifdef FP_ADD_SPECIALS_EN
    if (spec_q) result_d = spec_val_q;
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the whole datapath is cleared on reset, not just the FSM, so an
  // aborted operation leaves nothing behind and the outputs read zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_UNPACK;
      sx_q     <= 1'b0;  sy_q <= 1'b0;
      ex_q     <= '0;    ey_q <= '0;
      mx_q     <= '0;    my_q <= '0;
      my_al_q  <= '0;
      sum_q    <= '0;
      sign_q   <= 1'b0;
      n_q      <= '0;
      exp_n_q  <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef FP_ADD_SPECIALS_EN
      spec_q     <= 1'b0;
      spec_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_UNPACK: begin
          sx_q <= sx_d;  sy_q <= sy_d;
          ex_q <= ex_d;  ey_q <= ey_d;
          mx_q <= mx_d;  my_q <= my_d;
`ifdef FP_ADD_SPECIALS_EN
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
`endif
        end
        ST_ALIGN:  my_al_q <= my_al_d;
        ST_ADDSUB: begin
          sum_q  <= sum_d;
          sign_q <= sign_d;
        end
        ST_NORM: begin
          n_q     <= n_d;
          exp_n_q <= exp_n_d;
          zero_q  <= zero_d;
        end
        ST_ROUND: begin
          result_q <= result_d;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule : fp_add

// File: tb/tb_fp_add.sv
module tb_fp_add;
  import fp_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] dataa, datab;
  logic [31:0] result;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  fp_add dut (
    .clk    (clk),
    .reset  (reset),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset for one cycle with the operands applied, release it, and
  // return the outputs sampled after LATENCY+1 rising edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic d);
    @(negedge clk);
    reset = 1'b0;
    dataa = a;
    datab = b;
    @(negedge clk);
    reset = 1'b1;
    repeat (LATENCY + 1) @(negedge clk);
    r = result;
    d = done;
  endtask

  task automatic run_table(input vec_t tbl[$]);
    logic [31:0] r;
    logic        d;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, r, d);
      checks++;
      if (d !== 1'b1) begin
        failures++;
        $display("FAIL %s done: got %b want 1", tbl[i].name, d);
      end
      checks++;
      if (r !== tbl[i].exp) begin
        failures++;
        $display("FAIL %s result: got %h want %h", tbl[i].name, r, tbl[i].exp);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    dataa = 32'h3F80_0000;
    datab = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result: got %h want 00000000", result);
    end
  endtask

  task automatic test_same_sign;
    vec_t t[$];
    t.push_back('{32'h3FC0_0000, 32'h3FA0_0000, 32'h4030_0000, "add_1p5_1p25"});
    t.push_back('{32'h3D80_0000, 32'h3D80_0000, 32'h3E00_0000, "add_equal"});
    t.push_back('{32'hBFC0_0000, 32'hBFC0_0000, 32'hC040_0000, "add_neg"});
    run_table(t);
  endtask

  task automatic test_align;
    vec_t t[$];
    t.push_back('{32'h3D80_0000, 32'h3F80_0000, 32'h3F88_0000, "align_small_first"});
    t.push_back('{32'h3F80_0000, 32'hBE00_0000, 32'h3F60_0000, "align_sub"});
    // Gap of 26: only sticky survives, no rounding effect.
    t.push_back('{32'h3F80_0000, 32'h3280_0000, 32'h3F80_0000, "align_gap26"});
    run_table(t);
  endtask

  task automatic test_subtract;
    vec_t t[$];
    t.push_back('{32'h3FC0_0000, 32'hBFA0_0000, 32'h3E80_0000, "sub_pos"});
    t.push_back('{32'h3FA0_0000, 32'hBFC0_0000, 32'hBE80_0000, "sub_neg"});
    run_table(t);
  endtask

  task automatic test_zero;
    vec_t t[$];
    t.push_back('{32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, "cancel"});
    t.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_zero"});
    t.push_back('{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "negzero_negzero"});
    t.push_back('{32'h4049_0FDB, 32'h0000_0000, 32'h4049_0FDB, "x_plus_zero"});
    t.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, "denorm_flush"});
    // 1.0000001p-126 - 1p-126 underflows to a zero carrying X's sign.
    t.push_back('{32'h8080_0001, 32'h0080_0000, 32'h8000_0000, "underflow"});
    run_table(t);
  endtask

  task automatic test_round;
    vec_t t[$];
    t.push_back('{32'h3F85_1EB8, 32'hC048_F5C3, 32'hC006_6667, "round_mixed"});
    // Exact half-ulp: even LSB stays, odd LSB rounds up.
    t.push_back('{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even"});
    t.push_back('{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "tie_odd"});
    run_table(t);
  endtask

  task automatic test_overflow;
    vec_t t[$];
    t.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow"});
    run_table(t);
  endtask

`ifdef FP_ADD_SPECIALS_EN
  task automatic test_specials;
    vec_t t[$];
    t.push_back('{32'h7F80_0000, 32'hFF80_0000, QNAN, "inf_minus_inf"});
    t.push_back('{32'h7FC0_1234, 32'h3F80_0000, QNAN, "nan_in"});
    t.push_back('{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "inf_plus_finite"});
    t.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, "inf_plus_inf"});
    run_table(t);
  endtask
`endif

  // done must be low after edge LATENCY-1 and high after edge LATENCY.
  task automatic test_latency;
    @(negedge clk);
    reset = 1'b0;
    dataa = 32'h3FC0_0000;
    datab = 32'h3FA0_0000;
    @(negedge clk);
    reset = 1'b1;
    repeat (LATENCY - 1) @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL latency_early: got done=%b result=%h want 0/00000000", done, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 32'h4030_0000) begin
      failures++;
      $display("FAIL latency_exact: got done=%b result=%h want 1/40300000", done, result);
    end
  endtask

  task automatic test_hold;
    logic [31:0] r;
    logic        d;
    run_op(32'h3F80_0000, 32'hBE00_0000, r, d);
    dataa = 32'h4000_0000;
    datab = 32'h4000_0000;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 32'h3F60_0000) begin
      failures++;
      $display("FAIL hold: got done=%b result=%h want 1/3F600000", done, result);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] r;
    logic        d;
    // Abort with a result already held: clear must be immediate.
    run_op(32'h3FC0_0000, 32'hBFA0_0000, r, d);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: got done=%b result=%h want 0/00000000", done, result);
    end
    // Abort after the third edge of a new operation.
    @(negedge clk);
    dataa = 32'h7F7F_FFFF;
    datab = 32'h7F7F_FFFF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_cycle3: got done=%b result=%h want 0/00000000", done, result);
    end
    // A fresh operation afterwards is unaffected by the aborted one.
    run_op(32'h3D80_0000, 32'h3F80_0000, r, d);
    checks++;
    if (d !== 1'b1 || r !== 32'h3F88_0000) begin
      failures++;
      $display("FAIL after_abort: got done=%b result=%h want 1/3F880000", d, r);
    end
  endtask

  initial begin
    reset = 1'b0;
    dataa = '0;
    datab = '0;
    test_reset();
    test_same_sign();
    test_align();
    test_subtract();
    test_zero();
    test_round();
    test_overflow();
`ifdef FP_ADD_SPECIALS_EN
    test_specials();
`endif
    test_latency();
    test_hold();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fp_add
